sram_fifo_ctrl: RTL and testbench

// - Initiator side of the 64b x 256 single-port SRAM macro interface (active-low CEN/WEN, 1-cycle registered-address read).
// - Wraps the macro as a valid/ready streaming FIFO: writes incoming words, reads them back in order to a 3-entry output buffer.
// - Arbitrates the single port between write and read each cycle. Sits between PE-array result streams and the next pipeline stage.

---
 rtl/sram_fifo_ctrl.sv | 87 ++++++++
 tb/tb_sram_fifo_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO over a 64b x 256 single-port SRAM with a 3-entry output buffer.
// Defining SRAM_FIFO_CTRL_FLUSH_EN adds a synchronous flush input that clears all state.
module sram_fifo_ctrl #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 8
) (
   input  logic              CLK,
   input  logic              reset,
`ifdef SRAM_FIFO_CTRL_FLUSH_EN
   input  logic              flush,
`endif
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W+1:0] count,
   output logic              full,
   output logic              empty,
   output logic              sram_CEN,
   output logic              sram_WEN,
   output logic [ADDR_W-1:0] sram_A,
   output logic [DATA_W-1:0] sram_D,
   input  logic [DATA_W-1:0] sram_Q
);
   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
   logic [ADDR_W-1:0] wr_ptr, rd_ptr;
   logic [ADDR_W:0]   sram_cnt;
   logic              inflight, wr_pend, fl, rd_req, rd_grant, wr, pop;
   logic [1:0]        obuf_cnt, wpos;
   logic [DATA_W-1:0] obuf [3];
`ifdef SRAM_FIFO_CTRL_FLUSH_EN
   assign fl = flush;
`else
   assign fl = 1'b0;
`endif
   // reads only depend on registered state, so out_ready never reaches the SRAM port
   assign full      = sram_cnt == DEPTH;
   assign rd_req    = (sram_cnt != '0) && (({1'b0, obuf_cnt} + {2'b0, inflight}) < 3'd3);
   assign rd_grant  = rd_req && !wr_pend && !fl;
   assign in_ready  = !reset && !full && !rd_grant && !fl;
   assign wr        = in_valid && in_ready;
   assign out_valid = obuf_cnt != 2'd0;
   assign out_data  = obuf[0];
   assign pop       = out_valid && out_ready;
   assign wpos      = obuf_cnt - {1'b0, pop};
   assign count     = (ADDR_W+2)'(sram_cnt) + (ADDR_W+2)'(obuf_cnt) + (ADDR_W+2)'(inflight);
   assign empty     = count == '0;
   assign sram_CEN  = !(wr || rd_grant);
   assign sram_WEN  = !wr;
   assign sram_A    = wr ? wr_ptr : (rd_grant ? rd_ptr : '0);
   assign sram_D    = wr ? in_data : '0;
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         sram_cnt <= '0;
         inflight <= 1'b0;
         wr_pend  <= 1'b0;
         obuf_cnt <= '0;
         obuf[0]  <= '0;
         obuf[1]  <= '0;
         obuf[2]  <= '0;
      end else if (fl) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         sram_cnt <= '0;
         inflight <= 1'b0;
         wr_pend  <= 1'b0;
         obuf_cnt <= '0;
         obuf[0]  <= '0;
         obuf[1]  <= '0;
         obuf[2]  <= '0;
      end else begin
         wr_pend  <= in_valid && !in_ready && !full;
         inflight <= rd_grant;
         wr_ptr   <= wr ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr   <= rd_grant ? rd_ptr + 1'b1 : rd_ptr;
         sram_cnt <= wr ? sram_cnt + 1'b1 : (rd_grant ? sram_cnt - 1'b1 : sram_cnt);
         obuf_cnt <= obuf_cnt + {1'b0, inflight} - {1'b0, pop};
         obuf[0]  <= (inflight && wpos == 2'd0) ? sram_Q : (pop ? obuf[1] : obuf[0]);
         obuf[1]  <= (inflight && wpos == 2'd1) ? sram_Q : (pop ? obuf[2] : obuf[1]);
         obuf[2]  <= (inflight && wpos == 2'd2) ? sram_Q : obuf[2];
      end
   end
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed bench for sram_fifo_ctrl with a behavioural SRAM and an in-order scoreboard.
// Flush scenario is compiled in when SRAM_FIFO_CTRL_FLUSH_EN is defined.
module tb_sram_fifo_ctrl;
   logic        CLK = 1'b0, reset = 1'b1, in_valid = 1'b1, out_ready = 1'b0;
   logic        in_ready, out_valid, full, empty, sram_CEN, sram_WEN;
   logic [63:0] in_data = '0, out_data, sram_D, sram_Q;
   logic [9:0]  count;
   logic [7:0]  sram_A;
`ifdef SRAM_FIFO_CTRL_FLUSH_EN
   logic        flush = 1'b0;
`endif
   logic [63:0] mem [256];
   logic [63:0] exp_q [$];
   logic [63:0] nxt;
   logic [7:0]  wptr = '0;
   int n_tests = 0, n_fail = 0, bad = 0, sbad = 0, stall = 0, acc = 0, pops = 0, t_acc = -1, t_ov = -1;
   bit a;

   sram_fifo_ctrl dut (
      .CLK(CLK), .reset(reset),
`ifdef SRAM_FIFO_CTRL_FLUSH_EN
      .flush(flush),
`endif
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count), .full(full), .empty(empty),
      .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A), .sram_D(sram_D), .sram_Q(sram_Q)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK)
      if (!sram_CEN) begin
         if (!sram_WEN) mem[sram_A] <= sram_D;
         else sram_Q <= mem[sram_A];
      end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // one clock: drive at negedge, observe 1ns later, return at next negedge
   task automatic cycle(input bit iv, input logic [63:0] d, input bit ordy, output bit ok);
      in_valid = iv;
      in_data = d;
      out_ready = ordy;
      #1;
      ok = in_valid && in_ready;
      if (ok) begin
         exp_q.push_back(d);
         acc++;
         if (sram_CEN || sram_WEN || sram_A !== wptr || sram_D !== d) bad++;
         wptr++;
      end
      if (!sram_CEN && !sram_WEN && !ok) bad++;
      if (sram_CEN && (sram_A !== '0 || sram_D !== '0)) bad++;
      if (count > 10'd259) bad++;
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) bad++;
         else if (out_data !== exp_q.pop_front()) bad++;
         pops++;
      end
      if (full) stall = 0;
      else if (iv && !ok) begin
         stall++;
         if (stall > 1) sbad++;
      end else stall = 0;
      @(negedge CLK);
   endtask

   task automatic stream(input int n, input int budget, input string tag);
      int sent = 0;
      bit ok, done = 0;
      for (int c = 0; c < budget && !done; c++) begin
         if (out_valid && t_ov < 0) t_ov = c;
         cycle(sent < n, nxt, 1'b1, ok);
         if (ok) begin
            if (t_acc < 0) t_acc = c;
            sent++;
            nxt++;
         end
         done = sent == n && exp_q.size() == 0;
      end
      check({tag, "_done"}, done, 1);
   endtask

   initial begin
      repeat (2) @(negedge CLK);
      #1;
      check("rst_in_ready", in_ready, 0);
      check("rst_cen", sram_CEN, 1);
      check("rst_wen", sram_WEN, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_empty", empty, 1);
      check("rst_full", full, 0);
      check("rst_count", count, 0);
      check("rst_addr", sram_A, 0);
      check("rst_wdata", sram_D, 0);
      reset = 1'b0;
      in_valid = 1'b0;
      @(negedge CLK);
      check("rel_in_ready", in_ready, 1);
      check("rel_empty", empty, 1);

      nxt = 64'h11;
      stream(5, 40, "seq");
      check("seq_latency", t_ov - t_acc, 3);
      check("seq_order", bad, 0);
      check("seq_pops", pops, 5);

      // a write arriving while a read is wanted loses once, then wins
      cycle(1, 64'hA1, 1, a);
      check("st_acc_a1", a, 1);
      check("st_rd_ready", in_ready, 0);
      check("st_rd_cen", sram_CEN, 0);
      check("st_rd_wen", sram_WEN, 1);
      check("st_rd_addr", sram_A, 5);
      cycle(1, 64'hA2, 1, a);
      check("st_stall_a2", a, 0);
      check("st_win_ready", in_ready, 1);
      check("st_win_wen", sram_WEN, 0);
      check("st_win_data", sram_D, 64'hA2);
      cycle(1, 64'hA2, 1, a);
      check("st_acc_a2", a, 1);
      nxt = 64'h0;
      stream(0, 40, "st");
      check("st_order", bad, 0);
      check("st_stall_once", sbad, 0);

      acc = 0;
      nxt = 64'h1000;
      for (int c = 0; c < 600; c++) begin
         cycle(1, nxt, 0, a);
         if (a) nxt++;
      end
      check("fill_accepted", acc, 259);
      check("fill_full", full, 1);
      check("fill_in_ready", in_ready, 0);
      check("fill_count", count, 259);
      check("fill_out_valid", out_valid, 1);
      check("fill_head", out_data, 64'h1000);
      check("fill_cen", sram_CEN, 1);
      stream(40, 1500, "mix");
      check("mix_order", bad, 0);
      check("mix_stall_once", sbad, 0);
      check("mix_empty", empty, 1);

      nxt = 64'h300;
      for (int c = 0; c < 4; c++) begin
         cycle(1, nxt, 0, a);
         if (a) nxt++;
      end
      reset = 1'b1;
      #1;
      check("mrst_count", count, 0);
      check("mrst_out_valid", out_valid, 0);
      check("mrst_in_ready", in_ready, 0);
      check("mrst_cen", sram_CEN, 1);
      @(negedge CLK);
      reset = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      wptr = '0;
      bad = 0;
      nxt = 64'h400;
      stream(3, 40, "mrst");
      check("mrst_order", bad, 0);

      pops = 0;
      nxt = 64'h5000;
      stream(300, 1500, "wrap");
      check("wrap_order", bad, 0);
      check("wrap_pops", pops, 300);
      check("wrap_stall_once", sbad, 0);
      check("wrap_empty", empty, 1);

`ifdef SRAM_FIFO_CTRL_FLUSH_EN
      nxt = 64'h200;
      for (int c = 0; c < 6; c++) begin
         cycle(1, nxt, 0, a);
         if (a) nxt++;
      end
      check("fl_pre_count", count, 3);
      check("fl_pre_valid", out_valid, 1);
      flush = 1'b1;
      out_ready = 1'b1;
      #1;
      check("fl_in_ready", in_ready, 0);
      check("fl_cen", sram_CEN, 1);
      @(negedge CLK);
      flush = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b0;
      check("fl_count", count, 0);
      check("fl_out_valid", out_valid, 0);
      check("fl_empty", empty, 1);
      exp_q.delete();
      wptr = '0;
      bad = 0;
      pops = 0;
      nxt = 64'hAA;
      stream(1, 40, "fl");
      check("fl_first_word", bad, 0);
      check("fl_pops", pops, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
